// File: rtl/wb_host_pkg.sv
// Shared types and defaults for the Wishbone host master.
// The optional bus timeout is enabled by defining WB_HOST_TIMEOUT_EN.
package wb_host_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUS  = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    localparam int AW_DEFAULT      = 32;
    localparam int DW_DEFAULT      = 32;
    localparam int TIMEOUT_DEFAULT = 255;

    localparam logic RSP_ERR_NONE    = 1'b0;
    localparam logic RSP_ERR_TIMEOUT = 1'b1;

endpackage

// File: rtl/wb_host_timeout.sv
// Bus-cycle watchdog: counts consecutive BUS cycles without ack.
// Only instantiated when WB_HOST_TIMEOUT_EN is defined.
module wb_host_timeout #(
    parameter int LIMIT = 255
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam logic [16:0] LIMIT_W = 17'(LIMIT);

    logic [15:0] cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (clear) begin
            cnt_q <= '0;
        end else if (enable) begin
            cnt_q <= cnt_q + 16'd1;
        end
    end

    // The current cycle is the LIMIT-th unacknowledged one when cnt_q = LIMIT-1.
    assign expired = enable && (({1'b0, cnt_q} + 17'd1) == LIMIT_W);

endmodule

// File: rtl/wb_host_master.sv
// Wishbone classic single-transfer initiator driven by a valid/ready command stream.
// Define WB_HOST_TIMEOUT_EN to abort cycles that see no ack within TIMEOUT_CYCLES.
module wb_host_master
    import wb_host_pkg::*;
#(
    parameter int AW             = AW_DEFAULT,
    parameter int DW             = DW_DEFAULT,
    parameter int TIMEOUT_CYCLES = TIMEOUT_DEFAULT
) (
    input  logic            wb_clk_i,
    input  logic            wb_rst_ni,
    input  logic            cmd_valid_i,
    output logic            cmd_ready_o,
    input  logic            cmd_we_i,
    input  logic [AW-1:0]   cmd_adr_i,
    input  logic [DW-1:0]   cmd_dat_i,
    input  logic [DW/8-1:0] cmd_sel_i,
    output logic            rsp_valid_o,
    input  logic            rsp_ready_i,
    output logic [DW-1:0]   rsp_dat_o,
    output logic            rsp_err_o,
    output logic            wbm_cyc_o,
    output logic            wbm_stb_o,
    output logic            wbm_we_o,
    output logic [DW/8-1:0] wbm_sel_o,
    output logic [AW-1:0]   wbm_adr_o,
    output logic [DW-1:0]   wbm_dat_o,
    input  logic [DW-1:0]   wbm_dat_i,
    input  logic            wbm_ack_i,
    output logic            busy_o
);

    state_e state_q;
    logic   rsp_err_q;
    logic   timeout_hit;

    // Both streams follow valid/ready: a beat transfers on a rising edge where valid && ready.
    assign cmd_ready_o = (state_q == ST_IDLE);
    assign rsp_err_o   = rsp_err_q;

`ifdef WB_HOST_TIMEOUT_EN
    wb_host_timeout #(
        .LIMIT (TIMEOUT_CYCLES)
    ) u_timeout (
        .clk     (wb_clk_i),
        .rst_n   (wb_rst_ni),
        .clear   (state_q != ST_BUS),
        .enable  ((state_q == ST_BUS) && !wbm_ack_i),
        .expired (timeout_hit)
    );
`else
    assign timeout_hit = 1'b0;
`endif

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            state_q     <= ST_IDLE;
            wbm_cyc_o   <= 1'b0;
            wbm_stb_o   <= 1'b0;
            wbm_we_o    <= 1'b0;
            wbm_sel_o   <= '0;
            wbm_adr_o   <= '0;
            wbm_dat_o   <= '0;
            rsp_valid_o <= 1'b0;
            rsp_dat_o   <= '0;
            rsp_err_q   <= RSP_ERR_NONE;
            busy_o      <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (cmd_valid_i) begin
                        wbm_we_o  <= cmd_we_i;
                        wbm_adr_o <= cmd_adr_i;
                        wbm_sel_o <= cmd_sel_i;
                        wbm_dat_o <= cmd_we_i ? cmd_dat_i : '0;
                        wbm_cyc_o <= 1'b1;
                        wbm_stb_o <= 1'b1;
                        busy_o    <= 1'b1;
                        state_q   <= ST_BUS;
                    end
                end
                ST_BUS: begin
                    // Ack takes priority over a timeout expiring in the same cycle.
                    if (wbm_ack_i) begin
                        wbm_cyc_o   <= 1'b0;
                        wbm_stb_o   <= 1'b0;
                        rsp_dat_o   <= wbm_we_o ? '0 : wbm_dat_i;
                        rsp_err_q   <= RSP_ERR_NONE;
                        rsp_valid_o <= 1'b1;
                        state_q     <= ST_RESP;
                    end else if (timeout_hit) begin
                        wbm_cyc_o   <= 1'b0;
                        wbm_stb_o   <= 1'b0;
                        rsp_dat_o   <= '0;
                        rsp_err_q   <= RSP_ERR_TIMEOUT;
                        rsp_valid_o <= 1'b1;
                        state_q     <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    if (rsp_ready_i) begin
                        rsp_valid_o <= 1'b0;
                        busy_o      <= 1'b0;
                        state_q     <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_wb_host_master.sv
// Self-checking bench for wb_host_master: directed cases plus randomized transfers
// scored against a queue of expected responses.
module tb_wb_host_master;

    localparam int AW         = 32;
    localparam int DW         = 32;
    localparam int SW         = DW / 8;
    localparam int TO         = 4;
    localparam int WAIT_BOUND = 64;

    logic          clk;
    logic          rst_n;
    logic          cmd_valid;
    logic          cmd_ready;
    logic          cmd_we;
    logic [AW-1:0] cmd_adr;
    logic [DW-1:0] cmd_dat;
    logic [SW-1:0] cmd_sel;
    logic          rsp_valid;
    logic          rsp_ready;
    logic [DW-1:0] rsp_dat;
    logic          rsp_err;
    logic          wbm_cyc;
    logic          wbm_stb;
    logic          wbm_we;
    logic [SW-1:0] wbm_sel;
    logic [AW-1:0] wbm_adr;
    logic [DW-1:0] wbm_dat_o;
    logic [DW-1:0] wbm_dat_i;
    logic          wbm_ack;
    logic          busy;

    logic [DW:0] exp_q[$];
    int          n_checks = 0;
    int          n_fail   = 0;

    wb_host_master #(
        .AW             (AW),
        .DW             (DW),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .wb_clk_i    (clk),
        .wb_rst_ni   (rst_n),
        .cmd_valid_i (cmd_valid),
        .cmd_ready_o (cmd_ready),
        .cmd_we_i    (cmd_we),
        .cmd_adr_i   (cmd_adr),
        .cmd_dat_i   (cmd_dat),
        .cmd_sel_i   (cmd_sel),
        .rsp_valid_o (rsp_valid),
        .rsp_ready_i (rsp_ready),
        .rsp_dat_o   (rsp_dat),
        .rsp_err_o   (rsp_err),
        .wbm_cyc_o   (wbm_cyc),
        .wbm_stb_o   (wbm_stb),
        .wbm_we_o    (wbm_we),
        .wbm_sel_o   (wbm_sel),
        .wbm_adr_o   (wbm_adr),
        .wbm_dat_o   (wbm_dat_o),
        .wbm_dat_i   (wbm_dat_i),
        .wbm_ack_i   (wbm_ack),
        .busy_o      (busy)
    );

    // clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference: stb is high for ack_lat+1 cycles unless the watchdog cuts it short.
    function automatic int exp_stb_cycles(input int ack_lat);
`ifdef WB_HOST_TIMEOUT_EN
        return (ack_lat + 1 > TO) ? TO : ack_lat + 1;
`else
        return ack_lat + 1;
`endif
    endfunction

    // driver: one full command -> Wishbone cycle -> response
    task automatic do_txn(input logic we, input logic [AW-1:0] adr, input logic [DW-1:0] dat,
                          input logic [SW-1:0] sel, input int ack_lat, input logic [DW-1:0] rdata,
                          input int bp, input bit hold_cmd, input bit stray_ack);
        logic [DW:0] exp;
        logic [DW:0] got;
        int          n;
        bit          timed_out;
        timed_out = (ack_lat + 1) > exp_stb_cycles(ack_lat);
        exp = timed_out ? {1'b1, {DW{1'b0}}} : {1'b0, (we ? {DW{1'b0}} : rdata)};
        exp_q.push_back(exp);

        check_eq("cmd_ready_idle", cmd_ready, 1);
        cmd_valid = 1'b1;
        cmd_we    = we;
        cmd_adr   = adr;
        cmd_dat   = dat;
        cmd_sel   = sel;
        step();
        cmd_valid = 1'b0;
        cmd_adr   = $urandom;
        cmd_dat   = $urandom;
        cmd_sel   = SW'($urandom);
        cmd_we    = ~we;

        check_eq("cyc_start", wbm_cyc, 1);
        check_eq("stb_start", wbm_stb, 1);
        check_eq("wbm_we", wbm_we, we);
        check_eq("wbm_adr", wbm_adr, adr);
        check_eq("wbm_sel", wbm_sel, sel);
        check_eq("wbm_dat", wbm_dat_o, we ? dat : '0);
        check_eq("busy_bus", busy, 1);
        check_eq("cmd_ready_bus", cmd_ready, 0);

        n = 0;
        while (wbm_stb && n < WAIT_BOUND) begin
            if (n == ack_lat) begin
                wbm_ack   = 1'b1;
                wbm_dat_i = rdata;
            end
            step();
            wbm_ack   = 1'b0;
            wbm_dat_i = $urandom;
            n++;
            if (wbm_stb) check_eq("adr_hold", wbm_adr, adr);
        end
        check_eq("stb_cycles", n, exp_stb_cycles(ack_lat));
        check_eq("cyc_end", wbm_cyc, 0);
        check_eq("rsp_valid", rsp_valid, 1);
        got = {rsp_err, rsp_dat};

        for (int i = 0; i < bp; i++) begin
            rsp_ready = 1'b0;
            if (hold_cmd) cmd_valid = 1'b1;
            if (stray_ack && i == 0) wbm_ack = 1'b1;
            step();
            wbm_ack = 1'b0;
            check_eq("rsp_valid_hold", rsp_valid, 1);
            check_eq("rsp_stable", {rsp_err, rsp_dat}, got);
            check_eq("cmd_ready_resp", cmd_ready, 0);
            check_eq("cyc_resp", wbm_cyc, 0);
        end
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
        cmd_valid = 1'b0;
        check_eq("rsp_valid_clr", rsp_valid, 0);
        check_eq("cmd_ready_after", cmd_ready, 1);
        check_eq("no_accept_in_handshake", wbm_cyc, 0);
        check_eq("busy_after", busy, 0);

        // scoreboard
        if (exp_q.size() == 0) begin
            check_eq("sb_underflow", 1, 0);
        end else begin
            exp = exp_q.pop_front();
            check_eq("rsp", got, exp);
        end
    endtask

    initial begin
        rst_n     = 1'b1;
        cmd_valid = 1'b0;
        cmd_we    = 1'b0;
        cmd_adr   = '0;
        cmd_dat   = '0;
        cmd_sel   = '0;
        rsp_ready = 1'b0;
        wbm_dat_i = '0;
        wbm_ack   = 1'b0;
        #2 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_cmd_ready", cmd_ready, 1);
        check_eq("rst_rsp_valid", rsp_valid, 0);
        check_eq("rst_cyc", wbm_cyc, 0);
        check_eq("rst_stb", wbm_stb, 0);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_adr", wbm_adr, 0);
        check_eq("rst_err", rsp_err, 0);
        @(negedge clk);
        rst_n = 1'b1;
        step();

        // write with a two-wait-state slave
        do_txn(1'b1, 32'h3000_0004, 32'hDEAD_BEEF, 4'hF, 2, 32'hA5A5_A5A5, 0, 1'b0, 1'b0);
        // read with a zero-wait slave
        do_txn(1'b0, 32'h3000_0010, 32'h0, 4'hF, 0, 32'h1234_5678, 0, 1'b0, 1'b0);
        // backpressure with command held and a stray ack in RESP
        do_txn(1'b0, 32'h3000_0020, 32'h0, 4'h3, 1, 32'hCAFE_F00D, 5, 1'b1, 1'b1);

        // stray ack in IDLE
        wbm_ack = 1'b1;
        step();
        wbm_ack = 1'b0;
        step();
        check_eq("stray_idle_rsp", rsp_valid, 0);
        check_eq("stray_idle_ready", cmd_ready, 1);
        check_eq("stray_idle_cyc", wbm_cyc, 0);

        // reset in the middle of a bus cycle
        cmd_valid = 1'b1;
        cmd_we    = 1'b1;
        cmd_adr   = 32'h3000_0100;
        cmd_dat   = 32'h5555_AAAA;
        cmd_sel   = 4'hF;
        step();
        cmd_valid = 1'b0;
        check_eq("mid_cyc_before", wbm_cyc, 1);
        #2 rst_n = 1'b0;
        #1;
        check_eq("mid_rst_cyc", wbm_cyc, 0);
        check_eq("mid_rst_stb", wbm_stb, 0);
        check_eq("mid_rst_busy", busy, 0);
        @(negedge clk);
        rst_n = 1'b1;
        step();
        check_eq("post_rst_ready", cmd_ready, 1);
        check_eq("post_rst_rsp", rsp_valid, 0);
        check_eq("post_rst_cyc", wbm_cyc, 0);

`ifdef WB_HOST_TIMEOUT_EN
        // slave never answers, then answers exactly on the expiring cycle
        do_txn(1'b0, 32'h3000_0200, 32'h0, 4'hF, 50, 32'h7777_7777, 0, 1'b0, 1'b0);
        do_txn(1'b0, 32'h3000_0204, 32'h0, 4'hF, TO - 1, 32'h8888_8888, 0, 1'b0, 1'b0);
`else
        // without the watchdog a slow slave is simply waited for
        do_txn(1'b0, 32'h3000_0200, 32'h0, 4'hF, 20, 32'h7777_7777, 0, 1'b0, 1'b0);
`endif

        // randomized transfers
        for (int t = 0; t < 30; t++) begin
            do_txn(1'($urandom), $urandom, $urandom, SW'($urandom), $urandom_range(0, TO - 1),
                   $urandom, $urandom_range(0, 3), 1'($urandom), 1'($urandom));
        end

        check_eq("sb_drain", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
